// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch slice.
// Holds memory access encodings, the default reset PC and a helper that sizes
// counters able to hold the values 0..depth inclusive.
package fetch_pkg;

    localparam logic [1:0] ACC_BYTE = 2'b00;
    localparam logic [1:0] ACC_HALF = 2'b01;
    localparam logic [1:0] ACC_WORD = 2'b10;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8002_0000;

    // Counter width that holds 0..depth, e.g. 3 bits for depth 4.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read bus between the fetch unit and main memory.
// master (fetch side): drives mem_req, mem_addr, mem_rw, mem_access_size;
//                      receives mem_ready, mem_rvalid, mem_rdata.
// slave (memory side): the mirror image.
// Responses are in order, one per accepted request, latency of at least one cycle.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rw;
    logic [1:0]         mem_access_size;
    logic               mem_ready;
    logic               mem_rvalid;
    logic [INSTR_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_rw, mem_access_size,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_rw, mem_access_size,
        output mem_ready, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer holding {pc, instruction} entries.
// Ports: clk, rst_n (sync active-low), flush (empties the buffer, wins over push),
//        push/wdata, pop/rdata (head shown combinationally), count, empty, full.
// A push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          push,
    input  logic [WIDTH-1:0]              wdata,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rdata,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          empty,
    output logic                          full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem_q[rd_ptr_q];
        count   = count_q;
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the PC, issues word reads over the memory bus,
// buffers returned instructions with their PCs and hands them to decode.
// Ports: clk_in, rst_n_in (sync active-low), stall_in (decode back-pressure),
//        redirect_in/redirect_pc_in (load new PC, flush), mem (fetch_unit_if master),
//        instr_valid_out/instr_out/pc_out (FIFO head to decode).
// Optional macro FETCH_PERF_EN adds instr_count_out and bubble_count_out.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 32,
    parameter int unsigned        INSTR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter int unsigned        PC_STEP    = 4
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               stall_in,
    input  logic               redirect_in,
    input  logic [ADDR_W-1:0]  redirect_pc_in,
    fetch_unit_if.master       mem,
    output logic               instr_valid_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        instr_count_out,
    output logic [31:0]        bubble_count_out
`endif
);
    localparam int unsigned CNT_W = cnt_width(FIFO_DEPTH);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned ENT_W = ADDR_W + INSTR_W;

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] resp_pc_q;
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  drop_cnt_q;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;
    logic [ENT_W-1:0]  fifo_rdata;
    logic              accept;
    logic              drop;

    always_comb begin
        // Credit check: every outstanding request has a reserved FIFO slot.
        mem.mem_req = rst_n_in && !redirect_in &&
                      (({1'b0, inflight_q} + {1'b0, fifo_count}) < SUM_W'(FIFO_DEPTH));
        mem.mem_addr        = pc_q;
        mem.mem_rw          = MEM_READ;
        mem.mem_access_size = ACC_WORD;

        accept          = mem.mem_req && mem.mem_ready;
        drop            = mem.mem_rvalid && (drop_cnt_q != '0);
        instr_valid_out = rst_n_in && !fifo_empty;
        fifo_pop        = instr_valid_out && !stall_in;
        fifo_push       = mem.mem_rvalid && (drop_cnt_q == '0) && !redirect_in &&
                          (!fifo_full || fifo_pop);

        pc_out    = fifo_rdata[ENT_W-1 -: ADDR_W];
        instr_out = fifo_rdata[INSTR_W-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_q + CNT_W'(accept) - CNT_W'(mem.mem_rvalid);
            if (redirect_in) begin
                pc_q       <= redirect_pc_in;
                resp_pc_q  <= redirect_pc_in;
                // Everything still outstanding after this cycle's response is stale.
                drop_cnt_q <= inflight_q - CNT_W'(mem.mem_rvalid);
            end else begin
                if (accept)    pc_q       <= pc_q + ADDR_W'(PC_STEP);
                if (fifo_push) resp_pc_q  <= resp_pc_q + ADDR_W'(PC_STEP);
                if (drop)      drop_cnt_q <= drop_cnt_q - 1'b1;
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .flush (redirect_in),
        .push  (fifo_push),
        .wdata ({resp_pc_q, mem.mem_rdata}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] instr_count_q;
    logic [31:0] bubble_count_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            instr_count_q  <= '0;
            bubble_count_q <= '0;
        end else begin
            if (fifo_pop)                        instr_count_q  <= instr_count_q + 1'b1;
            if (!stall_in && !instr_valid_out)   bubble_count_q <= bubble_count_q + 1'b1;
        end
    end

    always_comb begin
        instr_count_out  = instr_count_q;
        bubble_count_out = bubble_count_q;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order variable-latency memory model.
// Memory returns data = ~address so every delivered instruction pairs with its PC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
`ifdef FETCH_PERF_EN
    logic [31:0] instr_count;
    logic [31:0] bubble_count;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int unsigned lat     = 1;
    int unsigned cyc     = 0;
    int unsigned acc_cnt = 0;
    int unsigned due_q[$];
    logic [31:0] addr_q[$];

    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) mif ();

    fetch_unit dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .stall_in        (stall),
        .redirect_in     (redirect),
        .redirect_pc_in  (redirect_pc),
        .mem             (mif),
        .instr_valid_out (instr_valid),
        .instr_out       (instr),
        .pc_out          (pc)
`ifdef FETCH_PERF_EN
        ,
        .instr_count_out  (instr_count),
        .bubble_count_out (bubble_count)
`endif
    );

    // In-order memory: request accepted at edge E answers at edge E+lat.
    always @(posedge clk) begin
        if (!rst_n) begin
            due_q.delete();
            addr_q.delete();
            acc_cnt = 0;
        end else begin
            if (mif.mem_rvalid === 1'b1) begin
                void'(due_q.pop_front());
                void'(addr_q.pop_front());
            end
            if (mif.mem_req && mif.mem_ready) begin
                due_q.push_back(cyc + lat);
                addr_q.push_back(mif.mem_addr);
                acc_cnt++;
            end
        end
        cyc++;
        #1;
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = ~addr_q[0];
        end else begin
            mif.mem_rvalid = 1'b0;
            mif.mem_rdata  = '0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mif.mem_ready = 1'b1; lat = 1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req",   32'(mif.mem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_rw",    32'(mif.mem_rw), 32'd0);
        check("rst_size",  32'(mif.mem_access_size), 32'd2);
        @(posedge clk); #1; rst_n = 1'b1;

        // Streaming, zero wait states, latency 1
        @(negedge clk);
        check("t1_addr0",  mif.mem_addr, 32'h8002_0000);
        check("t1_valid0", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("t1_addr1",  mif.mem_addr, 32'h8002_0004);
        check("t1_valid1", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("t1_valid2", 32'(instr_valid), 32'd1);
        check("t1_pc2",    pc, 32'h8002_0000);
        check("t1_instr2", instr, 32'h7FFD_FFFF);
        check("t1_addr2",  mif.mem_addr, 32'h8002_0008);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check("t1_stream_valid", 32'(instr_valid), 32'd1);
            check("t1_stream_pc",    pc, 32'h8002_0000 + 32'(4 * i));
            check("t1_stream_instr", instr, ~(32'h8002_0000 + 32'(4 * i)));
        end

        // Stall from start: credit limit stops fetching at 4
        stall = 1'b1;
        do_reset();
        repeat (10) @(negedge clk);
        check("t2_accepts", acc_cnt, 32'd4);
        check("t2_req",     32'(mif.mem_req), 32'd0);
        check("t2_pc_head", pc, 32'h8002_0000);
        @(posedge clk); #1; stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_pop_pc", pc, 32'h8002_0000 + 32'(4 * i));
            if (i == 1) begin
                check("t2_resume_req",  32'(mif.mem_req), 32'd1);
                check("t2_resume_addr", mif.mem_addr, 32'h8002_0010);
            end
        end

        // Memory not ready for 3 cycles: address held, PC moves only on accept
        mif.mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_hold_req",  32'(mif.mem_req), 32'd1);
            check("t3_hold_addr", mif.mem_addr, 32'h8002_0000);
        end
        @(posedge clk); #1; mif.mem_ready = 1'b1;
        @(negedge clk);
        check("t3_pre_addr", mif.mem_addr, 32'h8002_0000);
        check("t3_pre_acc",  acc_cnt, 32'd0);
        @(negedge clk);
        check("t3_post_addr", mif.mem_addr, 32'h8002_0004);
        check("t3_post_acc",  acc_cnt, 32'd1);

        // Latency 3, redirect with two requests in flight
        lat = 3;
        do_reset();
        @(posedge clk);
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h8003_0000;
        @(negedge clk);
        check("t4_redir_req",      32'(mif.mem_req), 32'd0);
        check("t4_inflight",       32'(dut.inflight_q), 32'd2);
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk);
        check("t4_valid_after",    32'(instr_valid), 32'd0);
        check("t4_drop_cnt",       32'(dut.drop_cnt_q), 32'd2);
        check("t4_new_addr",       mif.mem_addr, 32'h8003_0000);
        n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_first_latency",  32'(n), 32'd4);
        check("t4_first_pc",       pc, 32'h8003_0000);
        check("t4_first_instr",    instr, 32'h7FFC_FFFF);

        // Redirect coinciding with a response while stalled
        lat = 1; stall = 1'b1;
        do_reset();
        @(posedge clk); #1;
        redirect = 1'b1; redirect_pc = 32'h8004_0000;
        @(negedge clk);
        check("t5_redir_req",  32'(mif.mem_req), 32'd0);
        check("t5_inflight",   32'(dut.inflight_q), 32'd1);
        @(posedge clk); #1; redirect = 1'b0;
        @(negedge clk);
        check("t5_drop_cnt",   32'(dut.drop_cnt_q), 32'd0);
        check("t5_inflight0",  32'(dut.inflight_q), 32'd0);
        check("t5_valid",      32'(instr_valid), 32'd0);
        check("t5_addr",       mif.mem_addr, 32'h8004_0000);
        @(negedge clk);
        @(negedge clk);
        check("t5_head_valid", 32'(instr_valid), 32'd1);
        check("t5_head_pc",    pc, 32'h8004_0000);
        check("t5_head_instr", instr, 32'h7FFB_FFFF);

`ifdef FETCH_PERF_EN
        // 3 bubble cycles then 10 pops, then stall and reset mid-stream
        stall = 1'b0; mif.mem_ready = 1'b0;
        do_reset();
        @(posedge clk); #1; mif.mem_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1; stall = 1'b1;
        @(negedge clk);
        check("perf_instr",  instr_count, 32'd10);
        check("perf_bubble", bubble_count, 32'd3);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("perf_rst_instr",  instr_count, 32'd0);
        check("perf_rst_bubble", bubble_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
